// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced button level to press/release/click/long/repeat event pulses
`timescale 1ns/1ps

module button_event_decoder #(
    parameter int ACTIVE_LOW  = 1,
    parameter int CNT_W       = 26,
    parameter int LONG_TIME   = 50_000_000,
    parameter int REPEAT_TIME = 10_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       btn_level,
    input  logic       enable,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_click,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        WAIT_RELEASE,
        IDLE,
        PRESSED,
        LONG
    } state_t;

    // Terminal counts are compared against the pre-increment counter value.
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'((REPEAT_TIME == 0) ? 0 : REPEAT_TIME - 1);
    localparam bit               REPEAT_EN = (REPEAT_TIME != 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic pressed;

    state_t           state_q,         state_d;
    logic [CNT_W-1:0] counter_q,       counter_d;
    logic             press_q,         press_d;
    logic             release_q,       release_d;
    logic             short_q,         short_d;
    logic             long_q,          long_d;
    logic             repeat_q,        repeat_d;
    logic             held_q,          held_d;
    logic [7:0]       press_count_q,   press_count_d;

    assign pressed = (ACTIVE_LOW != 0) ? ~btn_level : btn_level;

    // State, counter and registered outputs; reset lands in WAIT_RELEASE so an
    // active-low debouncer output of 0 after reset is not mistaken for a press.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= WAIT_RELEASE;
            counter_q     <= '0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            repeat_q      <= 1'b0;
            held_q        <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            press_q       <= press_d;
            release_q     <= release_d;
            short_q       <= short_d;
            long_q        <= long_d;
            repeat_q      <= repeat_d;
            held_q        <= held_d;
            press_count_q <= press_count_d;
        end
    end

    // Next-state and pulse decode; a release always beats a terminal count.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        press_d       = 1'b0;
        release_d     = 1'b0;
        short_d       = 1'b0;
        long_d        = 1'b0;
        repeat_d      = 1'b0;
        held_d        = held_q;
        press_count_d = press_count_q;

        if (!enable) begin
            state_d   = WAIT_RELEASE;
            counter_d = '0;
            held_d    = 1'b0;
        end else begin
            case (state_q)
                WAIT_RELEASE: begin
                    counter_d = '0;
                    held_d    = 1'b0;
                    if (!pressed) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    counter_d = '0;
                    held_d    = 1'b0;
                    if (pressed) begin
                        press_d       = 1'b1;
                        press_count_d = press_count_q + 8'd1;
                        held_d        = 1'b1;
                        state_d       = PRESSED;
                    end
                end
                PRESSED: begin
                    counter_d = counter_q + CNT_ONE;
                    if (!pressed) begin
                        release_d = 1'b1;
                        short_d   = 1'b1;
                        held_d    = 1'b0;
                        counter_d = '0;
                        state_d   = IDLE;
                    end else if (counter_q == LONG_TC) begin
                        long_d    = 1'b1;
                        counter_d = '0;
                        state_d   = LONG;
                    end
                end
                LONG: begin
                    if (!pressed) begin
                        release_d = 1'b1;
                        held_d    = 1'b0;
                        counter_d = '0;
                        state_d   = IDLE;
                    end else if (REPEAT_EN) begin
                        counter_d = counter_q + CNT_ONE;
                        if (counter_q == REPEAT_TC) begin
                            repeat_d  = 1'b1;
                            counter_d = '0;
                        end
                    end else begin
                        counter_d = '0;
                    end
                end
                default: begin
                    state_d   = WAIT_RELEASE;
                    counter_d = '0;
                    held_d    = 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_click   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder
`timescale 1ns/1ps

module tb_button_event_decoder;

    localparam int LONG = 8;
    localparam logic [4:0] P_PRESS = 5'b10000;
    localparam logic [4:0] P_REL   = 5'b01000;
    localparam logic [4:0] P_SHORT = 5'b00100;
    localparam logic [4:0] P_LONG  = 5'b00010;
    localparam logic [4:0] P_REP   = 5'b00001;

    logic       CLK;
    logic       RESET;
    logic       enable;
    logic       btn_a, btn_b;
    logic       press_a, rel_a, short_a, long_a, rep_a, held_a;
    logic       press_b, rel_b, short_b, long_b, rep_b, held_b;
    logic [7:0] count_a, count_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    logic [7:0] cnt_a = 8'd0;
    logic [7:0] cnt_b = 8'd0;
    logic [63:0] sb_q[$];

    button_event_decoder #(.ACTIVE_LOW(1), .CNT_W(8), .LONG_TIME(LONG), .REPEAT_TIME(4)) dut_a (
        .CLK(CLK), .RESET(RESET), .btn_level(btn_a), .enable(enable),
        .press_pulse(press_a), .release_pulse(rel_a), .short_click(short_a),
        .long_pulse(long_a), .repeat_pulse(rep_a), .held(held_a), .press_count(count_a)
    );

    button_event_decoder #(.ACTIVE_LOW(1), .CNT_W(8), .LONG_TIME(LONG), .REPEAT_TIME(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .btn_level(btn_b), .enable(enable),
        .press_pulse(press_b), .release_pulse(rel_b), .short_click(short_b),
        .long_pulse(long_b), .repeat_pulse(rep_b), .held(held_b), .press_count(count_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack(input int c, input bit sel, input logic [4:0] p, input logic [7:0] cnt);
        logic [31:0] cu;
        cu = c;
        return {18'd0, cu, sel, p, cnt};
    endfunction

    task automatic sb_compare(input logic [63:0] obs);
        if (sb_q.size() == 0) check_eq("unexpected_event", obs, 64'd0);
        else check_eq("event", obs, sb_q.pop_front());
    endtask

    // Event monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (|{press_a, rel_a, short_a, long_a, rep_a})
                sb_compare(pack(cyc, 1'b0, {press_a, rel_a, short_a, long_a, rep_a}, count_a));
            if (|{press_b, rel_b, short_b, long_b, rep_b})
                sb_compare(pack(cyc, 1'b1, {press_b, rel_b, short_b, long_b, rep_b}, count_b));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Hold the button of the selected instance for n sampled edges, then release.
    task automatic click(input bit sel, input int n);
        int t0;
        int rep;
        logic [7:0] c;
        bit got_long;
        rep = sel ? 0 : 4;
        if (sel) begin cnt_b = cnt_b + 8'd1; c = cnt_b; end
        else     begin cnt_a = cnt_a + 8'd1; c = cnt_a; end
        t0 = cyc + 1;
        sb_q.push_back(pack(t0, sel, P_PRESS, c));
        got_long = (LONG < n);
        if (got_long) begin
            sb_q.push_back(pack(t0 + LONG, sel, P_LONG, c));
            if (rep != 0)
                for (int t = t0 + LONG + rep; t < t0 + n; t += rep)
                    sb_q.push_back(pack(t, sel, P_REP, c));
        end
        sb_q.push_back(pack(t0 + n, sel, got_long ? P_REL : (P_REL | P_SHORT), c));
        if (sel) btn_b = 1'b0; else btn_a = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (i == 0) check_eq("held_on_press", {63'd0, sel ? held_b : held_a}, 64'd1);
        end
        if (sel) btn_b = 1'b1; else btn_a = 1'b1;
        step(1);
        check_eq("held_on_release", {63'd0, sel ? held_b : held_a}, 64'd0);
        step(1);
    endtask

    initial begin
        RESET  = 1'b1;
        enable = 1'b1;
        btn_a  = 1'b0;
        btn_b  = 1'b0;
        step(2);
        check_eq("reset_count", {56'd0, count_a}, 64'd0);
        check_eq("reset_held", {63'd0, held_a}, 64'd0);

        // Button reads pressed out of reset: no events until a release is seen.
        RESET = 1'b0;
        step(20);
        check_eq("post_reset_count", {56'd0, count_a}, 64'd0);
        check_eq("post_reset_held", {63'd0, held_a}, 64'd0);
        btn_a = 1'b1;
        btn_b = 1'b1;
        step(1);

        click(0, 5);                        // short click right after re-arm
        check_eq("count_after_short", {56'd0, count_a}, {56'd0, cnt_a});
        click(0, 30);                       // long press plus five repeats
        click(0, LONG);                     // release on terminal count
        click(0, LONG + 1);                 // one edge later: long, no repeat

        // Enable gating mid-hold.
        cnt_a = cnt_a + 8'd1;
        sb_q.push_back(pack(cyc + 1, 1'b0, P_PRESS, cnt_a));
        btn_a = 1'b0;
        step(3);
        check_eq("gate_held_before", {63'd0, held_a}, 64'd1);
        enable = 1'b0;
        step(1);
        check_eq("gate_held_drop", {63'd0, held_a}, 64'd0);
        step(2);
        check_eq("gate_count_frozen", {56'd0, count_a}, {56'd0, cnt_a});
        enable = 1'b1;
        step(12);
        check_eq("gate_no_rearm_held", {63'd0, held_a}, 64'd0);
        check_eq("gate_count_after", {56'd0, count_a}, {56'd0, cnt_a});
        btn_a = 1'b1;
        step(2);
        click(0, 3);

        // Wrap and no-repeat instance.
        for (int k = 0; k < 256; k++) click(1, 2);
        check_eq("wrap_count", {56'd0, count_b}, 64'd0);
        click(1, 20);

        // Asynchronous reset mid-hold.
        cnt_a = cnt_a + 8'd1;
        sb_q.push_back(pack(cyc + 1, 1'b0, P_PRESS, cnt_a));
        btn_a = 1'b0;
        step(3);
        RESET = 1'b1;
        #1;
        check_eq("async_reset_held", {63'd0, held_a}, 64'd0);
        check_eq("async_reset_count", {56'd0, count_a}, 64'd0);
        cnt_a = 8'd0;
        cnt_b = 8'd0;
        step(1);
        RESET = 1'b0;
        step(5);
        check_eq("reset_hold_no_press", {56'd0, count_a}, 64'd0);
        btn_a = 1'b1;
        step(2);
        click(0, 3);

        step(3);
        check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Sits directly downstream of the button debouncer. It consumes one debounced, clock-synchronous button level and turns it into single-cycle event pulses for the coprocessor control FSM: press, release, short click, long press and auto-repeat. It also provides a held flag and a wrap-around press counter. The input must already be debounced and synchronised; this block adds no synchroniser.

Parameters:
ACTIVE_LOW, 1, 1 = button reads pressed when btn_level is 0 (board KEYs); 0 = pressed when 1
CNT_W, 26, width of the hold-time counter
LONG_TIME, 50_000_000, cycles from press_pulse to long_pulse; legal range 2 to 2^CNT_W-1
REPEAT_TIME, 10_000_000, cycles between long_pulse/repeat pulses; 0 disables auto-repeat; otherwise legal range 2 to 2^CNT_W-1

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
btn_level  in  1  debounced button level from the debouncer
enable  in  1  1 = decode events; 0 = suppress all events and force re-arm
press_pulse  out  1  one-cycle pulse on press
release_pulse  out  1  one-cycle pulse on any release
short_click  out  1  one-cycle pulse on a release that happens before long_pulse
long_pulse  out  1  one-cycle pulse when the hold reaches LONG_TIME
repeat_pulse  out  1  one-cycle pulse every REPEAT_TIME cycles after long_pulse while still held
held  out  1  high while in PRESSED or LONG
press_count  out  8  count of accepted presses; wraps from 255 to 0

Behaviour:
- pressed = ACTIVE_LOW ? ~btn_level : btn_level, evaluated combinationally.
- All outputs are registered. Every pulse is high for exactly one cycle.
- Reset values: state = WAIT_RELEASE, counter = 0, all pulses = 0, held = 0, press_count = 0.
- FSM states: WAIT_RELEASE, IDLE, PRESSED, LONG.
- WAIT_RELEASE:
  - Goes to IDLE on the first edge where pressed = 0. No outputs are asserted.
  - Purpose: the debouncer resets its output to 0, which reads as pressed when ACTIVE_LOW = 1. This state prevents a false press after reset.
- IDLE:
  - On an edge where pressed = 1: press_pulse <= 1, press_count <= press_count + 1 (mod 256), counter <= 0, go to PRESSED.
  - Latency: press_pulse is high in the cycle after the first edge that samples pressed = 1.
- PRESSED:
  - Each edge, counter increments.
  - If pressed = 0: release_pulse <= 1, short_click <= 1, go to IDLE.
  - Else if counter == LONG_TIME-1: long_pulse <= 1, counter <= 0, go to LONG.
  - Result: long_pulse rises exactly LONG_TIME cycles after press_pulse.
- LONG:
  - Each edge, counter increments.
  - If pressed = 0: release_pulse <= 1 (short_click stays 0), go to IDLE.
  - Else if REPEAT_TIME != 0 and counter == REPEAT_TIME-1: repeat_pulse <= 1, counter <= 0.
  - If REPEAT_TIME == 0, the counter holds at 0 and never fires.
- Simultaneous events: release and terminal count on the same edge → release wins. No long_pulse or repeat_pulse is issued in that case.
- held = 1 in the cycle after entering PRESSED, and stays high through LONG. It drops in the same cycle release_pulse rises.
- A press in the same cycle as release_pulse is impossible: IDLE needs one edge to accept the next press. Minimum press-to-press spacing is therefore 2 cycles, which the debouncer output always satisfies.
- enable = 0, checked at every edge with priority over everything except RESET:
  - state <= WAIT_RELEASE, counter <= 0, held <= 0, pulses <= 0, press_count held.
  - After enable returns high, a button still being held produces no press until it is released.
- RESET mid-hold: everything returns to reset values immediately (asynchronous). Decoding re-arms only after a release is seen.
- Counter is CNT_W bits and never wraps in legal configurations. It is cleared on every state entry.

Test Plan:
1. Reset release (LONG_TIME=8, REPEAT_TIME=4, ACTIVE_LOW=1):
   - Stimulus: btn_level=0 at RESET deassert, held for 20 cycles, then 1.
   - Required: no pulses during the 20 cycles; press_count=0; FSM reaches IDLE one cycle after btn_level=1.
2. Short click:
   - Stimulus: from IDLE, btn_level=0 for 5 cycles, then 1.
   - Required: press_pulse one cycle; release_pulse and short_click together once, with no long_pulse; press_count=1.
3. Long hold with auto-repeat:
   - Stimulus: hold btn_level=0 for 30 cycles.
   - Required: long_pulse exactly 8 cycles after press_pulse; repeat_pulse at +4, +8, ... after long_pulse (5 repeats); on release, release_pulse only, short_click=0.
4. Release on terminal count:
   - Stimulus: release on the same edge as counter==LONG_TIME-1.
   - Required: release_pulse and short_click asserted; long_pulse never asserted.
5. Enable gating:
   - Stimulus: drop enable for 3 cycles mid-hold, then raise it with the button still held.
   - Required: held=0 immediately; no further events until release, then press; press_count unchanged during the gap.
6. Counter wrap and no-repeat mode:
   - Stimulus: 256 short clicks with REPEAT_TIME=0.
   - Required: press_count wraps to 0; a long hold gives exactly one long_pulse and zero repeat_pulse.
